fanin_rr_merge: RTL and testbench
=================================

Name: fanin_rr_merge

Overview:
- Merges up to NUM_IN ready/valid streams into one downstream stream. It is the fan-in counterpart of the fanout ready combiner.
- Per-input enable and select config gate which sources take part.
- A round-robin arbiter holds a lock on one source until that source sends a control token. This keeps token groups contiguous.
- A 2-entry registered output buffer gives full throughput and a registered out_valid/out_data. Sits between sam primitive outputs and a shared consumer port in the onyx fabric glue.

Parameters:
- NUM_IN, 6, number of input streams (2..16).
- DATA_W, 17, stream word width; bit DATA_W-1 is the control-token flag.
- SRC_W, $clog2(NUM_IN), width of the source index (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_en  input  NUM_IN  per-input enable (static during operation).
- cfg_sel  input  NUM_IN  per-input select; input i is eligible iff cfg_en[i] & cfg_sel[i].
- flush  input  1  synchronous clear of buffer and arbitration state.
- in_valid  input  NUM_IN  per-input valid.
- in_data  input  NUM_IN*DATA_W  packed input words; input i occupies [i*DATA_W +: DATA_W].
- in_ready  output  NUM_IN  per-input ready.
- out_valid  output  1  output word valid.
- out_data  output  DATA_W  output word.
- out_src  output  SRC_W  index of the input that produced out_data.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_src=0, in_ready=0, buffer count=0, rr_ptr=0, FSM=IDLE.
- Ineligible inputs: in_ready[i]=0 and never granted.
- Buffer: 2-entry FIFO, count 0..2.
  - space = (count<2) | (count==2 & out_ready), i.e. accept into a full buffer only when it drains the same cycle.
  - out_valid = (count!=0). out_data/out_src always come from the head entry.
  - Simultaneous push and pop at any count keeps the count unchanged.
- Latency: a word accepted at edge N appears at the output after edge N (out_valid high in cycle N+1). Sustained 1 word/cycle.
- FSM IDLE:
  - Grant = first i with eligible & in_valid, scanning from rr_ptr upward and wrapping modulo NUM_IN.
  - in_ready[grant]=space; all other in_ready=0.
  - On accept: if the word has a clear control flag, go to LOCKED with lock_src=grant. Otherwise stay IDLE.
  - Either way, rr_ptr = grant+1 modulo NUM_IN (wrapping from NUM_IN-1 to 0).
- FSM LOCKED:
  - Only lock_src is eligible for grant; in_ready[lock_src]=space.
  - On accepting a word with the control flag set: return to IDLE with rr_ptr = lock_src+1.
  - If lock_src becomes ineligible (config change): return to IDLE next cycle, no word consumed.
- in_ready is combinational from in_valid, space and state. in_valid never depends on in_ready.
- flush: next edge sets count=0, FSM=IDLE, rr_ptr=0. No input is accepted in a flush cycle (all in_ready=0). flush has priority over push and pop.
- No eligible input valid: nothing pushed; rr_ptr unchanged.

Optional Feature:
- Macro FANIN_DROP_UNSEL_EN.
  - Defined: an input with cfg_en=1, cfg_sel=0 gets in_ready=1 and its words are discarded, so it never back-pressures. A disabled input (cfg_en=0) stays in_ready=0.
  - Not defined: all ineligible inputs hold in_ready=0.

Decomposition:
- Package fanin_merge_pkg holds:
  - typedef state_t {IDLE, LOCKED};
  - localparam CTRL_BIT = DATA_W-1;
  - function rr_pick(req, ptr) returning a grant index and a found flag.
- One sub-module, fanin_skid_buf (2-entry registered FIFO, DATA_W+SRC_W wide, with async reset and sync flush).
- The arbiter and FSM stay in the top module.

Test Plan:
- Reset and idle: hold rst_n=0, then release with all in_valid=0 -> out_valid=0, in_ready=0 for 10 cycles.
- Round-robin fairness: inputs 0, 2 and 5 eligible and continuously valid with plain words, out_ready=1 -> out_src sequence 0,2,5,0,2,5; one word per cycle after a 1-cycle latency.
- Token lock: input 1 sends 0x00A, 0x00B, then 0x1_0000 (control flag set) while input 3 is valid -> three words from src 1 back to back, then src 3.
- Backpressure: out_ready=0 for 5 cycles with input 0 streaming -> exactly 2 words buffered, in_ready[0]=0 while count=2; release -> words drain in order, none lost or duplicated.
- Eligibility: cfg_en=6'b111111, cfg_sel=6'b000010, all valid -> only src 1 output. With FANIN_DROP_UNSEL_EN: in_ready=6'b111111 and only src 1 words appear. Without it: in_ready=6'b000010.
- Flush mid-lock: LOCKED on src 4 with 2 words buffered, flush=1 for 1 cycle -> out_valid=0 next cycle, FSM=IDLE, next grant starts from src 0.

Source files
------------

// File: rtl/fanin_merge_pkg.sv
// Shared types and helpers for the fan-in round-robin merge.
package fanin_merge_pkg;

  localparam int DEF_NUM_IN = 6;
  localparam int DEF_DATA_W = 17;
  // Control-token flag position for the default word width.
  localparam int CTRL_BIT   = DEF_DATA_W - 1;
  // Widest fan-in the arbiter helper supports.
  localparam int MAX_IN     = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // First set bit of req at or after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_IN-1:0] req,
                                    input logic [3:0]        ptr,
                                    input int                n);
    pick_t      r;
    int         j;
    logic [3:0] jj;
    r = '0;
    for (int k = 0; k < MAX_IN; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      jj = j[3:0];
      if ((k < n) && !r.found && req[jj]) begin
        r.found = 1'b1;
        r.idx   = jj;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fanin_skid_buf.sv
// Two-entry registered FIFO. Head entry drives dout directly so the output
// is always a flop; a full buffer still accepts when it drains that cycle.
module fanin_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         out_ready,
  output logic         space,
  output logic         valid,
  output logic [W-1:0] dout
);

  logic [1:0]   count;
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         pop;

  assign pop   = (count != 2'd0) && out_ready;
  assign space = (count != 2'd2) || out_ready;
  assign valid = (count != 2'd0);
  assign dout  = head;

  // Head/tail storage and occupancy; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head  <= din;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= din;
          end else if (push) begin
            tail  <= din;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head <= tail;
            if (push) tail <= din;
            else      count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/fanin_rr_merge.sv
// Fan-in merge: round-robin arbitration over eligible inputs, locked onto one
// source until it sends a control token, feeding a 2-entry output buffer.
// Build option FANIN_DROP_UNSEL_EN: enabled-but-unselected inputs are held
// ready and their words discarded instead of back-pressuring.
//
// Handshake: a word moves when valid & ready are both high at a rising edge;
// valid never waits on ready, ready may depend on valid.
module fanin_rr_merge
  import fanin_merge_pkg::*;
#(
  parameter  int NUM_IN = DEF_NUM_IN,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int SRC_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN-1:0]        cfg_en,
  input  logic [NUM_IN-1:0]        cfg_sel,
  input  logic                     flush,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SRC_W-1:0]         out_src,
  input  logic                     out_ready,
  output state_t                   dbg_state
);

  localparam int CTRL  = DATA_W - 1;
  localparam int BUF_W = SRC_W + DATA_W;

  state_t              state;
  logic [SRC_W-1:0]    rr_ptr;
  logic [SRC_W-1:0]    lock_src;
  logic [SRC_W-1:0]    gnt;
  logic [NUM_IN-1:0]   elig;
  logic [NUM_IN-1:0]   req;
  pick_t               pick;
  logic                gnt_ok;
  logic                lock_lost;
  logic                space;
  logic                accept;
  logic [DATA_W-1:0]   gnt_word;
  logic [BUF_W-1:0]    buf_dout;

  assign elig      = cfg_en & cfg_sel;
  assign req       = elig & in_valid;
  assign dbg_state = state;

  function automatic logic [SRC_W-1:0] ptr_after(input logic [SRC_W-1:0] s);
    return (int'(s) == NUM_IN - 1) ? '0 : s + 1'b1;
  endfunction

  // Grant selection and per-input ready.
  always_comb begin
    pick      = rr_pick(MAX_IN'(req), 4'(rr_ptr), NUM_IN);
    lock_lost = (state == LOCKED) && !elig[lock_src];
    if (state == LOCKED) begin
      gnt    = lock_src;
      gnt_ok = req[lock_src];
    end else begin
      gnt    = pick.idx[SRC_W-1:0];
      gnt_ok = pick.found;
    end
    gnt_word = in_data[int'(gnt)*DATA_W +: DATA_W];
    accept   = gnt_ok && space && !flush && !lock_lost;
    in_ready = '0;
    if (!flush && !lock_lost) begin
      if (state == LOCKED) in_ready[lock_src] = space;
      else if (gnt_ok)     in_ready[gnt]      = space;
    end
`ifdef FANIN_DROP_UNSEL_EN
    if (!flush) in_ready = in_ready | (cfg_en & ~cfg_sel);
`endif
  end

  // Arbitration FSM: lock on a plain word, release on a control token.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_src <= '0;
    end else if (flush) begin
      state  <= IDLE;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rr_ptr <= ptr_after(gnt);
            if (!gnt_word[CTRL]) begin
              state    <= LOCKED;
              lock_src <= gnt;
            end
          end
        end
        LOCKED: begin
          if (lock_lost) begin
            state <= IDLE;
          end else if (accept && gnt_word[CTRL]) begin
            state  <= IDLE;
            rr_ptr <= ptr_after(lock_src);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fanin_skid_buf #(.W(BUF_W)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (accept),
    .din       ({gnt, gnt_word}),
    .out_ready (out_ready),
    .space     (space),
    .valid     (out_valid),
    .dout      (buf_dout)
  );

  assign out_src  = buf_dout[BUF_W-1:DATA_W];
  assign out_data = buf_dout[DATA_W-1:0];

endmodule

// File: tb/tb_fanin_rr_merge.sv
// Bench for fanin_rr_merge: directed scenarios plus randomized token groups,
// scored against an acceptance-order queue and a group-contiguity rule.
module tb_fanin_rr_merge;
  import fanin_merge_pkg::*;

  localparam int NUM_IN = 6;
  localparam int DATA_W = 17;
  localparam int SRC_W  = 3;
  localparam int E_W    = SRC_W + DATA_W;
`ifdef FANIN_DROP_UNSEL_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_IN-1:0]        cfg_en;
  logic [NUM_IN-1:0]        cfg_sel;
  logic                     flush;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [SRC_W-1:0]         out_src;
  logic                     out_ready;
  state_t                   dbg_state;

  fanin_rr_merge #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_en    (cfg_en),
    .cfg_sel   (cfg_sel),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [DATA_W-1:0] src_q[NUM_IN][$];  // words each source still has to send
  logic [E_W-1:0]    exp_q[$];          // accepted, not yet delivered {src,data}
  logic [E_W-1:0]    out_log[$];
  int                out_cyc[$];
  int                acc_cyc[$];
  logic [NUM_IN-1:0] offering;
  logic              grp_open;
  logic [SRC_W-1:0]  grp_src;
  bit                gaps;
  bit                rand_ready;
  int                rr_seq[3] = '{0, 2, 5};

  // ---------------- driver ----------------
  task automatic drive_inputs();
    for (int i = 0; i < NUM_IN; i++) begin
      if (!offering[i] && src_q[i].size() > 0 && (!gaps || $urandom_range(0, 3) != 0))
        offering[i] = 1'b1;
      in_valid[i] = offering[i];
      if (offering[i]) in_data[i*DATA_W +: DATA_W] = src_q[i][0];
      else             in_data[i*DATA_W +: DATA_W] = '0;
    end
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NUM_IN; i++) if (src_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  // One clock: sample 1 time unit after the negedge, score, advance.
  task automatic cycle();
    int                n_acc;
    logic [E_W-1:0]    got;
    logic [E_W-1:0]    want;
    logic [NUM_IN-1:0] elig;
    logic [NUM_IN-1:0] exp_inel;
    #1;
    elig     = cfg_en & cfg_sel;
    exp_inel = (DROP && !flush) ? (cfg_en & ~cfg_sel) : '0;
    checks++;
    if ((in_ready & ~elig) !== exp_inel) begin
      failures++;
      $display("FAIL inelig_ready cyc=%0d got=%b want=%b", cyc, in_ready & ~elig, exp_inel);
    end
    if (flush) begin
      checks++;
      if (in_ready !== '0) begin
        failures++;
        $display("FAIL flush_ready cyc=%0d got=%b want=0", cyc, in_ready);
      end
      exp_q.delete();
      grp_open = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        got = {out_src, out_data};
        out_log.push_back(got);
        out_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_extra cyc=%0d got src=%0d data=%h want nothing", cyc, out_src, out_data);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL out_word cyc=%0d got src=%0d data=%h want src=%0d data=%h",
                     cyc, out_src, out_data, want[E_W-1:DATA_W], want[DATA_W-1:0]);
          end
        end
        checks++;
        if (grp_open && out_src !== grp_src) begin
          failures++;
          $display("FAIL group_split cyc=%0d got src=%0d want src=%0d", cyc, out_src, grp_src);
        end
        grp_open = !out_data[DATA_W-1];
        grp_src  = out_src;
      end
      n_acc = 0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          if (elig[i]) begin
            exp_q.push_back({SRC_W'(i), src_q[i][0]});
            acc_cyc.push_back(cyc);
            n_acc++;
          end
          void'(src_q[i].pop_front());
          offering[i] = 1'b0;
        end
      end
      checks++;
      if (n_acc > 1) begin
        failures++;
        $display("FAIL multi_accept cyc=%0d got=%0d want<=1", cyc, n_acc);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until_drained(input int max_cyc, input string name);
    int k = 0;
    while ((pending() || exp_q.size() != 0) && k < max_cyc) begin
      out_ready = rand_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
      drive_inputs();
      cycle();
      k++;
    end
    checks++;
    if (pending() || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout got pending=%0d outstanding=%0d want 0/0", name, pending(), exp_q.size());
    end
  endtask

  task automatic do_flush();
    for (int i = 0; i < NUM_IN; i++) src_q[i].delete();
    offering  = '0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b1;
    cycle();
    flush     = 1'b0;
    out_log.delete();
    out_cyc.delete();
    acc_cyc.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; cfg_en = '1; cfg_sel = '1; flush = 1'b0;
    in_valid = '0; in_data = '0; out_ready = 1'b0; offering = '0;
    grp_open = 1'b0; grp_src = '0; gaps = 1'b0; rand_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_src, in_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b d=%h s=%0d r=%b want all 0", out_valid, out_data, out_src, in_ready);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== '0) begin
        failures++;
        $display("FAIL idle_quiet k=%0d got v=%b r=%b want 0/0", k, out_valid, in_ready);
      end
    end
  endtask

  // Every word is a single-token group, so arbitration stays in IDLE.
  task automatic test_round_robin();
    logic [E_W-1:0] e;
    do_flush();
    cfg_en = 6'b100101; cfg_sel = 6'b100101;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 3; j++)
        src_q[rr_seq[j]].push_back({1'b1, 4'(rr_seq[j]), 12'(k)});
    run_until_drained(200, "rr");
    checks++;
    if (out_log.size() != 12) begin
      failures++;
      $display("FAIL rr_count got=%0d want=12", out_log.size());
    end else begin
      for (int j = 0; j < 12; j++) begin
        e = out_log[j];
        checks++;
        if (e[E_W-1:DATA_W] !== SRC_W'(rr_seq[j % 3])) begin
          failures++;
          $display("FAIL rr_order idx=%0d got src=%0d want src=%0d", j, e[E_W-1:DATA_W], rr_seq[j % 3]);
        end
        checks++;
        if (out_cyc[j] != out_cyc[0] + j) begin
          failures++;
          $display("FAIL rr_rate idx=%0d got cyc=%0d want cyc=%0d", j, out_cyc[j], out_cyc[0] + j);
        end
      end
    end
    checks++;
    if (acc_cyc.size() == 0 || out_cyc.size() == 0 || out_cyc[0] != acc_cyc[0] + 1) begin
      failures++;
      $display("FAIL rr_latency got out=%0d acc=%0d want out=acc+1",
               (out_cyc.size() != 0) ? out_cyc[0] : -1, (acc_cyc.size() != 0) ? acc_cyc[0] : -1);
    end
  endtask

  task automatic test_token_lock();
    logic [E_W-1:0] want[4];
    logic [E_W-1:0] e;
    do_flush();
    cfg_en = 6'b001010; cfg_sel = 6'b001010;
    src_q[1].push_back(17'h0000A);
    src_q[1].push_back(17'h0000B);
    src_q[1].push_back(17'h10000);
    src_q[3].push_back(17'h10033);
    want[0] = {3'd1, 17'h0000A};
    want[1] = {3'd1, 17'h0000B};
    want[2] = {3'd1, 17'h10000};
    want[3] = {3'd3, 17'h10033};
    run_until_drained(100, "lock");
    checks++;
    if (out_log.size() != 4) begin
      failures++;
      $display("FAIL lock_count got=%0d want=4", out_log.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        e = out_log[j];
        checks++;
        if (e !== want[j]) begin
          failures++;
          $display("FAIL lock_seq idx=%0d got=%h want=%h", j, e, want[j]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] words[8];
    logic [E_W-1:0]    e;
    do_flush();
    cfg_en = 6'b000001; cfg_sel = 6'b000001;
    for (int k = 0; k < 8; k++) begin
      words[k] = (k == 7) ? 17'h10107 : 17'(16'h0100 + k);
      src_q[0].push_back(words[k]);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_inputs();
      cycle();
      if (k >= 1) begin
        checks++;
        if (in_ready[0] !== 1'b0 || out_valid !== 1'b1 || out_data !== words[0]) begin
          failures++;
          $display("FAIL bp_hold k=%0d got r=%b v=%b d=%h want 0/1/%h", k, in_ready[0], out_valid, out_data, words[0]);
        end
      end
    end
    checks++;
    if (acc_cyc.size() != 2) begin
      failures++;
      $display("FAIL bp_buffered got=%0d want=2", acc_cyc.size());
    end
    run_until_drained(100, "bp");
    checks++;
    if (out_log.size() != 8) begin
      failures++;
      $display("FAIL bp_count got=%0d want=8", out_log.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        e = out_log[j];
        checks++;
        if (e[DATA_W-1:0] !== words[j]) begin
          failures++;
          $display("FAIL bp_order idx=%0d got=%h want=%h", j, e[DATA_W-1:0], words[j]);
        end
      end
    end
  endtask

  task automatic test_eligibility();
    logic [NUM_IN-1:0] want_rdy;
    logic [E_W-1:0]    e;
    do_flush();
    cfg_en = 6'b111111; cfg_sel = 6'b000010;
    for (int i = 0; i < NUM_IN; i++)
      for (int k = 0; k < 3; k++)
        src_q[i].push_back((i == 1 && k < 2) ? 17'(16'h0010 + k) : 17'(17'h10000 + 16 * i + k));
    want_rdy  = DROP ? 6'b111111 : 6'b000010;
    out_ready = 1'b1;
    drive_inputs();
    #1;
    checks++;
    if (in_ready !== want_rdy) begin
      failures++;
      $display("FAIL elig_ready got=%b want=%b", in_ready, want_rdy);
    end
    for (int k = 0; k < 12; k++) begin
      drive_inputs();
      cycle();
    end
    checks++;
    if (out_log.size() != 3) begin
      failures++;
      $display("FAIL elig_count got=%0d want=3", out_log.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        e = out_log[j];
        checks++;
        if (e[E_W-1:DATA_W] !== 3'd1) begin
          failures++;
          $display("FAIL elig_src idx=%0d got=%0d want=1", j, e[E_W-1:DATA_W]);
        end
      end
    end
    checks++;
    if (src_q[0].size() != (DROP ? 0 : 3)) begin
      failures++;
      $display("FAIL elig_drop got left=%0d want=%0d", src_q[0].size(), DROP ? 0 : 3);
    end
  endtask

  task automatic test_flush_lock();
    logic [E_W-1:0] e;
    do_flush();
    cfg_en = 6'b010001; cfg_sel = 6'b010001;
    for (int k = 0; k < 4; k++) src_q[4].push_back(17'(16'h0040 + k));
    src_q[4].push_back(17'h10044);
    out_ready = 1'b0;
    repeat (2) begin
      drive_inputs();
      cycle();
    end
    checks++;
    if (dbg_state !== LOCKED || out_valid !== 1'b1 || acc_cyc.size() != 2) begin
      failures++;
      $display("FAIL fl_setup got st=%0d v=%b acc=%0d want LOCKED/1/2", dbg_state, out_valid, acc_cyc.size());
    end
    src_q[0].push_back(17'h10001);
    drive_inputs();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL fl_clear got v=%b st=%0d want 0/IDLE", out_valid, dbg_state);
    end
    out_ready = 1'b1;
    drive_inputs();
    #1;
    checks++;
    if (in_ready !== 6'b000001) begin
      failures++;
      $display("FAIL fl_next_grant got=%b want=000001", in_ready);
    end
    run_until_drained(100, "fl");
    checks++;
    if (out_log.size() != 4) begin
      failures++;
      $display("FAIL fl_count got=%0d want=4", out_log.size());
    end else begin
      e = out_log[0];
      checks++;
      if (e !== {3'd0, 17'h10001}) begin
        failures++;
        $display("FAIL fl_first got=%h want=%h", e, {3'd0, 17'h10001});
      end
    end
  endtask

  task automatic test_random();
    logic [NUM_IN-1:0] el;
    logic [DATA_W-1:0] w;
    int                ng;
    int                len;
    for (int r = 0; r < 4; r++) begin
      do_flush();
      gaps       = 1'b1;
      rand_ready = 1'b1;
      el         = NUM_IN'($urandom_range(1, (1 << NUM_IN) - 1));
      cfg_en     = el;
      cfg_sel    = el;
      for (int i = 0; i < NUM_IN; i++) begin
        if (el[i]) begin
          ng = $urandom_range(1, 3);
          for (int g = 0; g < ng; g++) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
              w = DATA_W'($urandom);
              w[DATA_W-1] = (k == len - 1);
              src_q[i].push_back(w);
            end
          end
        end
      end
      run_until_drained(3000, "rand");
      gaps       = 1'b0;
      rand_ready = 1'b0;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_round_robin();
    test_token_lock();
    test_backpressure();
    test_eligibility();
    test_flush_lock();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
